// File: rtl/sram_mmio_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_mmio_responder_if
// Description : SRAM-style data port bundle between the core (master) and
//               the memory/MMIO responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface sram_mmio_responder_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // Core side: issues requests, consumes read data
    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    // Memory side: accepts requests, returns read data
    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_mmio_responder
// Description : Never-stalling responder for the core's SRAM data port.
//               One-cycle registered read latency, read-first semantics.
//               Decodes into an on-chip word RAM or an MMIO page holding
//               LED, synchronized switches, a free-running timer, a compare
//               register and a sticky match flag (timer_irq).
// Revision    : 1.0  initial release
// ============================================================================
module sram_mmio_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'h1FAF_0000
) (
    input  wire logic              clk,
    input  wire logic              resetn,
    sram_mmio_responder_if.slave   bus,
    output logic [15:0]            led,
    input  wire logic [7:0]        switch,
    output logic                   timer_irq
);

    // MMIO register offsets within the page
    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_SWITCH = 16'h0004;
    localparam logic [15:0] OFF_TIMER  = 16'h0008;
    localparam logic [15:0] OFF_CMP    = 16'h000C;
    localparam logic [15:0] OFF_STATUS = 16'h0010;

    // Byte-lane merge of new data into an existing word
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Word RAM, contents not reset
    logic [31:0] mem [2**RAM_AW];

    logic [31:0] rdata_q,   rdata_d;
    logic [15:0] led_q,     led_d;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] cmp_q,     cmp_d;
    logic        flag_q,    flag_d;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;

    logic              w_mmio_hit;
    logic [15:0]       w_off;
    logic [RAM_AW-1:0] w_idx;
    logic              w_wr;
    logic              w_ram_wr;
    logic              w_mmio_wr;
    logic [31:0]       w_mmio_rdata;
    logic              w_unused_addr;

    assign w_mmio_hit    = (bus.sram_addr[31:16] == MMIO_BASE[31:16]);
    assign w_off         = bus.sram_addr[15:0];
    assign w_idx         = bus.sram_addr[RAM_AW+1:2];
    assign w_wr          = bus.sram_en && (bus.sram_wen != 4'b0000);
    assign w_ram_wr      = w_wr && !w_mmio_hit;
    assign w_mmio_wr     = w_wr && w_mmio_hit;
    assign w_unused_addr = ^bus.sram_addr[1:0];

    // MMIO read mux: returns current (pre-write) register values
    always_comb begin
        w_mmio_rdata = 32'h0;
        case (w_off)
            OFF_LED:    w_mmio_rdata = {16'h0, led_q};
            OFF_SWITCH: w_mmio_rdata = {24'h0, sw_sync_q};
            OFF_TIMER:  w_mmio_rdata = timer_q;
            OFF_CMP:    w_mmio_rdata = cmp_q;
            OFF_STATUS: w_mmio_rdata = {31'h0, flag_q};
            default:    w_mmio_rdata = 32'h0;
        endcase
    end

    // Next-state for MMIO registers and the read-data register
    always_comb begin
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        cmp_d   = cmp_q;
        flag_d  = flag_q;
        rdata_d = rdata_q;

        if (w_mmio_wr) begin
            case (w_off)
                OFF_LED: begin
                    for (int i = 0; i < 2; i++) begin
                        if (bus.sram_wen[i]) led_d[8*i +: 8] = bus.sram_wdata[8*i +: 8];
                    end
                end
                // A TIMER write replaces this cycle's increment
                OFF_TIMER:  timer_d = lane_merge(timer_q, bus.sram_wdata, bus.sram_wen);
                OFF_CMP:    cmp_d   = lane_merge(cmp_q, bus.sram_wdata, bus.sram_wen);
                OFF_STATUS: if (bus.sram_wen[0] && bus.sram_wdata[0]) flag_d = 1'b0;
                default:    ;
            endcase
        end

        // Match compares the pre-increment timer; set beats a same-cycle clear
        if (timer_q == cmp_q) flag_d = 1'b1;

        if (bus.sram_en) begin
            rdata_d = w_mmio_hit ? w_mmio_rdata : mem[w_idx];
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'h0;
            led_q     <= 16'h0;
            timer_q   <= 32'h0;
            cmp_q     <= 32'hFFFF_FFFF;
            flag_q    <= 1'b0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            flag_q    <= flag_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM byte-lane write port; the read above sees the pre-write word
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sram_wen[i]) mem[w_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
            end
        end
    end

    assign bus.sram_rdata = rdata_q;
    assign led            = led_q;
    assign timer_irq      = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_mmio_responder
// Description : Directed, table-driven self-checking bench for the SRAM/MMIO
//               responder, plus hand sequences for timer, flag, switch sync
//               and asynchronous reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_mmio_responder;

    localparam logic [31:0] A_LED    = 32'h1FAF_0000;
    localparam logic [31:0] A_SWITCH = 32'h1FAF_0004;
    localparam logic [31:0] A_TIMER  = 32'h1FAF_0008;
    localparam logic [31:0] A_CMP    = 32'h1FAF_000C;
    localparam logic [31:0] A_STATUS = 32'h1FAF_0010;
    localparam logic [31:0] A_UNMAP  = 32'h1FAF_0020;

    logic        clk;
    logic        resetn;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    int n_checks;
    int n_errors;

    sram_mmio_responder_if bus ();

    sram_mmio_responder #(
        .RAM_AW    (12),
        .MMIO_BASE (32'h1FAF_0000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .led       (led),
        .switch    (switch),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request at the falling edge, sample just after the rising edge
    task automatic step(input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.sram_en    = en;
        bus.sram_wen   = wen;
        bus.sram_addr  = addr;
        bus.sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        tbl[0]  = '{1'b1, 4'h0, A_LED,         32'h0,         1'b1, 32'h0000_0000, 16'h0000};
        tbl[1]  = '{1'b1, 4'h0, A_CMP,         32'h0,         1'b1, 32'hFFFF_FFFF, 16'h0000};
        tbl[2]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'h0000};
        tbl[3]  = '{1'b1, 4'h4, 32'h0000_0010, 32'h00AA_0000, 1'b1, 32'hDEAD_BEEF, 16'h0000};
        tbl[4]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAA_BEEF, 16'h0000};
        tbl[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,         16'h0000};
        tbl[6]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0,         16'h0000};
        tbl[7]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h3333_3333, 1'b0, 32'h0,         16'h0000};
        tbl[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111, 16'h0000};
        tbl[9]  = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         1'b1, 32'h2222_2222, 16'h0000};
        tbl[10] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,         1'b1, 32'h3333_3333, 16'h0000};
        tbl[11] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'h3333_3333, 16'h0000};
        tbl[12] = '{1'b0, 4'hF, 32'h0000_0004, 32'h5555_5555, 1'b1, 32'h3333_3333, 16'h0000};
        tbl[13] = '{1'b1, 4'h0, 32'h0000_4010, 32'h0,         1'b1, 32'hDEAA_BEEF, 16'h0000};
        tbl[14] = '{1'b1, 4'hF, A_LED,         32'hFFFF_1234, 1'b1, 32'h0000_0000, 16'h1234};
        tbl[15] = '{1'b1, 4'h0, A_LED,         32'h0,         1'b1, 32'h0000_1234, 16'h1234};
        tbl[16] = '{1'b1, 4'h2, A_LED,         32'h0000_AB00, 1'b1, 32'h0000_1234, 16'hAB34};
        tbl[17] = '{1'b1, 4'h0, A_LED,         32'h0,         1'b1, 32'h0000_AB34, 16'hAB34};
        tbl[18] = '{1'b1, 4'hF, A_UNMAP,       32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 16'hAB34};
        tbl[19] = '{1'b1, 4'h0, A_UNMAP,       32'h0,         1'b1, 32'h0000_0000, 16'hAB34};
        tbl[20] = '{1'b1, 4'h0, A_STATUS,      32'h0,         1'b1, 32'h0000_0000, 16'hAB34};
        tbl[21] = '{1'b1, 4'h0, A_SWITCH,      32'h0,         1'b1, 32'h0000_0000, 16'hAB34};

        resetn         = 1'b0;
        switch         = 8'h00;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'h0;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", bus.sram_rdata, 32'h0);
        check("reset_led",   {16'h0, led}, 32'h0);
        check("reset_irq",   {31'h0, timer_irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Table: RAM, back-to-back, hold, alias, LED, unmapped, status, switch
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].chk) check($sformatf("vec%0d_rdata", i), bus.sram_rdata, tbl[i].exp_rdata);
            check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
        end

        // Timer count and compare match
        step(1'b1, 4'hF, A_TIMER, 32'h0000_0010);
        step(1'b1, 4'hF, A_CMP,   32'h0000_0014);
        check("cmp_prewrite", bus.sram_rdata, 32'hFFFF_FFFF);
        step(1'b1, 4'h0, A_TIMER, 32'h0);
        check("timer_0x11", bus.sram_rdata, 32'h0000_0011);
        step(1'b1, 4'h0, A_TIMER, 32'h0);
        check("timer_0x12", bus.sram_rdata, 32'h0000_0012);
        step(1'b1, 4'h0, A_STATUS, 32'h0);
        check("status_pre_match", bus.sram_rdata, 32'h0);
        check("irq_pre_match", {31'h0, timer_irq}, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        check("irq_after_match", {31'h0, timer_irq}, 32'h1);
        step(1'b1, 4'h0, A_STATUS, 32'h0);
        check("status_set", bus.sram_rdata, 32'h1);
        step(1'b1, 4'hF, A_STATUS, 32'h1);
        check("irq_w1c", {31'h0, timer_irq}, 32'h0);
        step(1'b1, 4'h0, A_STATUS, 32'h0);
        check("status_cleared", bus.sram_rdata, 32'h0);

        // W1C in the same cycle as a fresh match: set wins
        step(1'b1, 4'hF, A_TIMER, 32'h0000_0100);
        step(1'b1, 4'hF, A_CMP,   32'h0000_0102);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'hF, A_STATUS, 32'h1);
        check("irq_set_beats_clear", {31'h0, timer_irq}, 32'h1);
        step(1'b1, 4'h0, A_STATUS, 32'h0);
        check("status_set_beats_clear", bus.sram_rdata, 32'h1);
        step(1'b1, 4'hF, A_STATUS, 32'h1);
        check("irq_clear_again", {31'h0, timer_irq}, 32'h0);

        // Timer wrap
        step(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE);
        step(1'b1, 4'h0, A_TIMER, 32'h0);
        check("timer_fffffffe", bus.sram_rdata, 32'hFFFF_FFFE);
        step(1'b1, 4'h0, A_TIMER, 32'h0);
        check("timer_ffffffff", bus.sram_rdata, 32'hFFFF_FFFF);
        step(1'b1, 4'h0, A_TIMER, 32'h0);
        check("timer_wrap", bus.sram_rdata, 32'h0);

        // Switch synchronizer
        @(negedge clk);
        switch = 8'hA5;
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, A_SWITCH, 32'h0);
        check("switch_a5", bus.sram_rdata, 32'h0000_00A5);

        // Asynchronous reset in the middle of an LED write
        @(negedge clk);
        bus.sram_en    = 1'b1;
        bus.sram_wen   = 4'hF;
        bus.sram_addr  = A_LED;
        bus.sram_wdata = 32'h0000_5555;
        #2;
        resetn = 1'b0;
        #1;
        check("async_led",   {16'h0, led}, 32'h0);
        check("async_rdata", bus.sram_rdata, 32'h0);
        @(negedge clk);
        bus.sram_en = 1'b0;
        resetn      = 1'b1;
        step(1'b1, 4'h0, A_TIMER, 32'h0);
        check("timer_after_reset", bus.sram_rdata, 32'h0000_0001);
        step(1'b1, 4'h0, A_CMP, 32'h0);
        check("cmp_after_reset", bus.sram_rdata, 32'hFFFF_FFFF);
        step(1'b1, 4'h0, A_LED, 32'h0);
        check("led_read_after_reset", bus.sram_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
